// File: rtl/count_channel_sequencer_if.sv
// Command/counter/FIFO bundle around the measurement sequencer.
// master: command decoder, counter and FIFO side. slave: the sequencer.
interface count_channel_sequencer_if #(
  parameter int CW = 23
);
  logic          cmd_valid;
  logic [3:0]    cmd;
  logic [1:0]    chan_en;
  logic          fallingedge;
  logic [CW-1:0] count_p;
  logic [CW-1:0] count_m;
  logic          fifo_full;
  logic          count_mode;
  logic          enable1;
  logic          enable2;
  logic          fifo_wr_en;
  logic [CW:0]   fifo_data;
  logic          busy;
  logic          overflow;

  modport master (
    output cmd_valid, cmd, chan_en, fallingedge, count_p, count_m, fifo_full,
    input  count_mode, enable1, enable2, fifo_wr_en, fifo_data, busy, overflow
  );

  modport slave (
    input  cmd_valid, cmd, chan_en, fallingedge, count_p, count_m, fifo_full,
    output count_mode, enable1, enable2, fifo_wr_en, fifo_data, busy, overflow
  );
endinterface

// File: rtl/count_channel_sequencer.sv
// Channel scheduler for the pulse-counting datapath: settle, average 2^AVG_LOG2
// (count_p - count_m) results per visit and push one {channel, mean} word per visit.
module count_channel_sequencer #(
  parameter int CW       = 23,
  parameter int SETTLE   = 2,
  parameter int AVG_LOG2 = 2
) (
  input logic clk,
  input logic reset,
  count_channel_sequencer_if.slave bus
);
  localparam int ACW = CW + 1 + AVG_LOG2;
  localparam int SW  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [AVG_LOG2:0] N_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
  localparam logic signed [ACW-1:0] SAT_MAX = {{(AVG_LOG2 + 2){1'b0}}, {(CW - 1){1'b1}}};
  localparam logic signed [ACW-1:0] SAT_MIN = {{(AVG_LOG2 + 2){1'b1}}, {(CW - 1){1'b0}}};

  localparam logic [3:0] C_START  = 4'd1;
  localparam logic [3:0] C_SINGLE = 4'd2;
  localparam logic [3:0] C_STOP   = 4'd3;
  localparam logic [3:0] C_CLR    = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_WRITE} state_t;

  state_t                 state;
  logic [1:0]             en_lat;
  logic                   single;
  logic                   ch;
  logic                   smp_pend;
  logic [SW-1:0]          scnt;
  logic [AVG_LOG2:0]      n;
  logic signed [ACW-1:0]  acc;

  logic signed [CW:0]     diff;
  logic signed [ACW-1:0]  shifted;
  logic [CW-1:0]          mean;
  logic                   cmd_go, cmd_stop, cmd_clr;
  logic                   first_ch, nxt_ch, last_visit;

  always_comb begin
    diff       = $signed({1'b0, bus.count_p}) - $signed({1'b0, bus.count_m});
    shifted    = acc >>> AVG_LOG2;
    if (shifted > SAT_MAX)      mean = SAT_MAX[CW-1:0];
    else if (shifted < SAT_MIN) mean = SAT_MIN[CW-1:0];
    else                        mean = shifted[CW-1:0];
    cmd_go     = bus.cmd_valid && (bus.cmd == C_START || bus.cmd == C_SINGLE);
    cmd_stop   = bus.cmd_valid && (bus.cmd == C_STOP);
    cmd_clr    = bus.cmd_valid && (bus.cmd == C_CLR);
    first_ch   = ~bus.chan_en[0];
    nxt_ch     = (en_lat == 2'b11) ? ~ch : ch;
    // a single run ends after ch1 when both are enabled, else after its only channel
    last_visit = single && (en_lat != 2'b11 || ch);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      en_lat         <= 2'b00;
      single         <= 1'b0;
      ch             <= 1'b0;
      smp_pend       <= 1'b0;
      scnt           <= '0;
      n              <= '0;
      acc            <= '0;
      bus.count_mode <= 1'b0;
      bus.enable1    <= 1'b0;
      bus.enable2    <= 1'b0;
      bus.fifo_wr_en <= 1'b0;
      bus.fifo_data  <= '0;
      bus.busy       <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.fifo_wr_en <= 1'b0;
      // counter outputs are valid the cycle after the conversion pulse
      smp_pend       <= bus.fallingedge && (state == S_ACCUM);
      if (cmd_clr) bus.overflow <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (cmd_go && bus.chan_en != 2'b00) begin
            en_lat         <= bus.chan_en;
            single         <= (bus.cmd == C_SINGLE);
            ch             <= first_ch;
            scnt           <= '0;
            state          <= S_SETTLE;
            bus.count_mode <= first_ch;
            bus.enable1    <= ~first_ch;
            bus.enable2    <= first_ch;
            bus.busy       <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (SETTLE == 0 || (bus.fallingedge && int'(scnt) == SETTLE - 1)) begin
            acc   <= '0;
            n     <= '0;
            state <= S_ACCUM;
          end else if (bus.fallingedge) begin
            scnt <= scnt + 1'b1;
          end
        end
        S_ACCUM: begin
          if (smp_pend) begin
            acc <= acc + ACW'(diff);
            n   <= n + 1'b1;
            if (n == N_LAST) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!bus.fifo_full) begin
            bus.fifo_wr_en <= 1'b1;
            bus.fifo_data  <= {ch, mean};
          end else begin
            bus.overflow <= 1'b1;
          end
          if (last_visit) begin
            state       <= S_IDLE;
            bus.enable1 <= 1'b0;
            bus.enable2 <= 1'b0;
            bus.busy    <= 1'b0;
          end else begin
            ch             <= nxt_ch;
            scnt           <= '0;
            state          <= S_SETTLE;
            bus.count_mode <= nxt_ch;
            bus.enable1    <= ~nxt_ch;
            bus.enable2    <= nxt_ch;
          end
        end
        default: state <= S_IDLE;
      endcase

      // STOP overrides everything except the write already issued above
      if (cmd_stop) begin
        state       <= S_IDLE;
        bus.enable1 <= 1'b0;
        bus.enable2 <= 1'b0;
        bus.busy    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_count_channel_sequencer.sv
// Directed bench: dut_a uses SETTLE=2/AVG_LOG2=2, dut_b uses SETTLE=0/AVG_LOG2=0.
module tb_count_channel_sequencer;
  localparam int CW = 23;
  localparam logic [3:0] C_START  = 4'd1;
  localparam logic [3:0] C_SINGLE = 4'd2;
  localparam logic [3:0] C_STOP   = 4'd3;
  localparam logic [3:0] C_CLR    = 4'd4;
  localparam logic [CW-1:0] MAXC  = {CW{1'b1}};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  count_channel_sequencer_if #(.CW(CW)) a ();
  count_channel_sequencer_if #(.CW(CW)) b ();

  count_channel_sequencer #(.CW(CW), .SETTLE(2), .AVG_LOG2(2)) dut_a (
    .clk(clk), .reset(reset), .bus(a.slave));
  count_channel_sequencer #(.CW(CW), .SETTLE(0), .AVG_LOG2(0)) dut_b (
    .clk(clk), .reset(reset), .bus(b.slave));

  int total = 0;
  int bad   = 0;
  int wr_a  = 0;
  int wr_b  = 0;
  logic [CW:0] last_a = '0;
  logic [CW:0] last_b = '0;

  // {busy, enable1, enable2, overflow}
  wire [3:0] st_a = {a.busy, a.enable1, a.enable2, a.overflow};
  wire [3:0] st_b = {b.busy, b.enable1, b.enable2, b.overflow};

  always @(negedge clk) begin
    if (a.fifo_wr_en) begin wr_a++; last_a = a.fifo_data; end
    if (b.fifo_wr_en) begin wr_b++; last_b = b.fifo_data; end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_a(input logic [3:0] c, input logic [1:0] en);
    a.cmd = c; a.chan_en = en; a.cmd_valid = 1'b1; tick; a.cmd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] c, input logic [1:0] en);
    b.cmd = c; b.chan_en = en; b.cmd_valid = 1'b1; tick; b.cmd_valid = 1'b0;
  endtask

  task automatic pulse_a(input logic [CW-1:0] p, input logic [CW-1:0] m);
    a.count_p = p; a.count_m = m; a.fallingedge = 1'b1; tick;
    a.fallingedge = 1'b0; repeat (3) tick;
  endtask

  task automatic pulse_b(input logic [CW-1:0] p, input logic [CW-1:0] m);
    b.count_p = p; b.count_m = m; b.fallingedge = 1'b1; tick;
    b.fallingedge = 1'b0; repeat (3) tick;
  endtask

  // final sample of a visit; returns with dut_a sitting in its WRITE cycle
  task automatic pulse_last_a(input logic [CW-1:0] p, input logic [CW-1:0] m);
    a.count_p = p; a.count_m = m; a.fallingedge = 1'b1; tick;
    a.fallingedge = 1'b0; tick;
  endtask

  task automatic test_reset;
    #12;
    total++; if ({st_a, a.count_mode, a.fifo_wr_en} !== 6'b0) begin
      $display("FAIL reset_a_ctl: got %b want 000000", {st_a, a.count_mode, a.fifo_wr_en}); bad++; end
    total++; if (a.fifo_data !== '0) begin
      $display("FAIL reset_a_data: got %h want 0", a.fifo_data); bad++; end
    total++; if ({st_b, b.count_mode, b.fifo_wr_en} !== 6'b0) begin
      $display("FAIL reset_b_ctl: got %b want 000000", {st_b, b.count_mode, b.fifo_wr_en}); bad++; end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_continuous;
    int w0 = wr_a;
    send_a(C_START, 2'b11);
    total++; if ({st_a, a.count_mode} !== 5'b1100_0) begin
      $display("FAIL start_ch0: got %b want 11000", {st_a, a.count_mode}); bad++; end
    repeat (5) pulse_a(23'd100, 23'd40);
    total++; if (wr_a !== w0) begin
      $display("FAIL early_write: got %0d writes want %0d", wr_a, w0); bad++; end
    pulse_a(23'd100, 23'd40);
    total++; if (wr_a !== w0 + 1) begin
      $display("FAIL cont_write_cnt: got %0d want %0d", wr_a, w0 + 1); bad++; end
    total++; if (last_a !== {1'b0, 23'd60}) begin
      $display("FAIL cont_data: got %h want %h", last_a, {1'b0, 23'd60}); bad++; end
    total++; if ({st_a, a.count_mode} !== 5'b1010_1) begin
      $display("FAIL switch_ch1: got %b want 10101", {st_a, a.count_mode}); bad++; end
    send_a(C_STOP, 2'b00);
    total++; if (st_a !== 4'b0000) begin
      $display("FAIL cont_stop: got %b want 0000", st_a); bad++; end
  endtask

  task automatic test_single;
    int w0 = wr_a;
    send_a(C_SINGLE, 2'b10);
    total++; if ({st_a, a.count_mode} !== 5'b1010_1) begin
      $display("FAIL single_ch1: got %b want 10101", {st_a, a.count_mode}); bad++; end
    repeat (6) pulse_a(23'd10, 23'd30);
    total++; if (wr_a !== w0 + 1) begin
      $display("FAIL single_cnt: got %0d want %0d", wr_a, w0 + 1); bad++; end
    total++; if (last_a !== {1'b1, 23'h7FFFEC}) begin
      $display("FAIL single_neg: got %h want %h", last_a, {1'b1, 23'h7FFFEC}); bad++; end
    total++; if (st_a !== 4'b0000) begin
      $display("FAIL single_idle: got %b want 0000", st_a); bad++; end
  endtask

  task automatic test_overflow;
    int w0 = wr_a;
    a.fifo_full = 1'b1;
    send_a(C_SINGLE, 2'b01);
    repeat (5) pulse_a(23'd7, 23'd2);
    pulse_last_a(23'd7, 23'd2);
    // clear requested in the very cycle the result is dropped
    a.cmd = C_CLR; a.cmd_valid = 1'b1; tick; a.cmd_valid = 1'b0; tick;
    total++; if (wr_a !== w0) begin
      $display("FAIL full_nowrite: got %0d want %0d", wr_a, w0); bad++; end
    total++; if (st_a !== 4'b0001) begin
      $display("FAIL ovf_set: got %b want 0001", st_a); bad++; end
    a.fifo_full = 1'b0;
    send_a(C_CLR, 2'b00);
    total++; if (st_a !== 4'b0000) begin
      $display("FAIL ovf_clr: got %b want 0000", st_a); bad++; end
  endtask

  task automatic test_saturate;
    send_b(C_SINGLE, 2'b01); tick;
    pulse_b(MAXC, 23'd0);
    total++; if (wr_b !== 1 || last_b !== {1'b0, 23'h3FFFFF}) begin
      $display("FAIL sat_pos: got n=%0d %h want n=1 %h", wr_b, last_b, {1'b0, 23'h3FFFFF}); bad++; end
    send_b(C_SINGLE, 2'b01); tick;
    pulse_b(23'd0, MAXC);
    total++; if (wr_b !== 2 || last_b !== {1'b0, 23'h400000}) begin
      $display("FAIL sat_neg: got n=%0d %h want n=2 %h", wr_b, last_b, {1'b0, 23'h400000}); bad++; end
    send_b(C_SINGLE, 2'b11); tick;
    pulse_b(23'd5, 23'd3);
    total++; if (last_b !== {1'b0, 23'd2}) begin
      $display("FAIL b_ch0: got %h want %h", last_b, {1'b0, 23'd2}); bad++; end
    pulse_b(23'd5, 23'd3);
    total++; if (wr_b !== 4 || last_b !== {1'b1, 23'd2}) begin
      $display("FAIL b_ch1: got n=%0d %h want n=4 %h", wr_b, last_b, {1'b1, 23'd2}); bad++; end
    total++; if (st_b !== 4'b0000) begin
      $display("FAIL b_idle: got %b want 0000", st_b); bad++; end
  endtask

  task automatic test_stop;
    int w0 = wr_a;
    send_a(C_START, 2'b11);
    repeat (4) pulse_a(23'd100, 23'd40);
    send_a(C_STOP, 2'b00);
    total++; if (st_a !== 4'b0000) begin
      $display("FAIL stop_idle: got %b want 0000", st_a); bad++; end
    repeat (4) pulse_a(23'd100, 23'd40);
    total++; if (wr_a !== w0) begin
      $display("FAIL stop_nowrite: got %0d want %0d", wr_a, w0); bad++; end
    send_a(C_START, 2'b11);
    total++; if ({st_a, a.count_mode} !== 5'b1100_0) begin
      $display("FAIL restart_ch0: got %b want 11000", {st_a, a.count_mode}); bad++; end
    repeat (5) pulse_a(23'd50, 23'd20);
    pulse_last_a(23'd50, 23'd20);
    a.cmd = C_STOP; a.cmd_valid = 1'b1; tick; a.cmd_valid = 1'b0; tick;
    total++; if (wr_a !== w0 + 1 || last_a !== {1'b0, 23'd30}) begin
      $display("FAIL stop_in_write: got n=%0d %h want n=%0d %h", wr_a, last_a, w0 + 1, {1'b0, 23'd30}); bad++; end
    total++; if (st_a !== 4'b0000) begin
      $display("FAIL stop_write_idle: got %b want 0000", st_a); bad++; end
  endtask

  task automatic test_reset_mid;
    int w0 = wr_a;
    send_a(C_START, 2'b11);
    pulse_a(23'd9, 23'd1);
    reset = 1'b1; #1;
    total++; if ({st_a, a.count_mode, a.fifo_wr_en} !== 6'b0) begin
      $display("FAIL rst_settle: got %b want 000000", {st_a, a.count_mode, a.fifo_wr_en}); bad++; end
    #2 reset = 1'b0;
    tick;
    send_a(C_START, 2'b11);
    repeat (5) pulse_a(23'd9, 23'd1);
    pulse_last_a(23'd9, 23'd1);
    reset = 1'b1; #1;
    total++; if ({st_a, a.count_mode, a.fifo_wr_en} !== 6'b0 || a.fifo_data !== '0) begin
      $display("FAIL rst_write: got %b %h want 000000 0", {st_a, a.count_mode, a.fifo_wr_en}, a.fifo_data); bad++; end
    #2 reset = 1'b0;
    repeat (2) tick;
    total++; if (wr_a !== w0) begin
      $display("FAIL rst_nowrite: got %0d want %0d", wr_a, w0); bad++; end
    send_a(C_START, 2'b00);
    repeat (2) pulse_a(23'd9, 23'd1);
    total++; if (st_a !== 4'b0000 || wr_a !== w0) begin
      $display("FAIL no_chan: got %b n=%0d want 0000 n=%0d", st_a, wr_a, w0); bad++; end
  endtask

  initial begin
    a.cmd_valid = 1'b0; a.cmd = '0; a.chan_en = '0; a.fallingedge = 1'b0;
    a.count_p = '0; a.count_m = '0; a.fifo_full = 1'b0;
    b.cmd_valid = 1'b0; b.cmd = '0; b.chan_en = '0; b.fallingedge = 1'b0;
    b.count_p = '0; b.count_m = '0; b.fifo_full = 1'b0;
    test_reset;
    test_continuous;
    test_single;
    test_overflow;
    test_saturate;
    test_stop;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
